// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkgen_pkg
// Description : Shared types and helpers for the clock_enable_gen tick
//               generator: channel state encoding, cfg_ch width helper and
//               the effective-divisor helper (a divisor of 0 behaves as 1).
// Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

    // Channel state: stopped, periodic, or armed for a single tick.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHOT = 2'd2
    } ch_state_t;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Divisor actually used for counting: max(div, 1).
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage : clkgen_pkg
`default_nettype wire

// File: rtl/clkgen_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkgen_channel
// Description : One tick-generator channel: divisor register, counter,
//               IDLE/RUN/SHOT state machine, tick strobe and square wave.
//   clk_in     in   system clock
//   reset      in   synchronous active-high reset
//   wr         in   accepted configuration write addressed to this channel
//   wr_div     in   divisor to load on wr
//   wr_en      in   1 = start channel on wr, 0 = stop
//   wr_oneshot in   1 = one-shot, 0 = periodic (when wr_en)
//   restart    in   realign counter/square wave if channel is active
//   tick       out  registered one-cycle enable strobe
//   sq         out  registered square wave, toggles with each tick
//   busy       out  channel is counting (decoded from state register)
// Revision    : 1.0 - initial release
// ============================================================================
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50000,
    parameter bit RESET_RUN   = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_en,
    input  logic             wr_oneshot,
    input  logic             restart,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    localparam logic [DIV_W-1:0] c_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
    localparam ch_state_t        c_RESET_STATE = RESET_RUN ? ST_RUN : ST_IDLE;

    ch_state_t        r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_sq;

    ch_state_t        w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_tick_nxt;
    logic             w_sq_nxt;

    logic [DIV_W-1:0] w_eff;
    logic [DIV_W-1:0] w_last;
    logic             w_active;
    logic             w_due;

    assign w_eff    = DIV_W'(eff_div(32'(r_div)));
    assign w_last   = w_eff - DIV_W'(1);
    assign w_active = (r_state != ST_IDLE);
    // A due tick is always emitted, even when a write or restart lands on
    // the same edge; those only override the counter/square/state updates.
    assign w_due    = w_active && (r_cnt == w_last);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= c_RESET_STATE;
            r_div   <= c_DEFAULT_DIV;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_sq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tick  <= w_tick_nxt;
            r_sq    <= w_sq_nxt;
        end
    end

    // Later assignments override earlier ones: write > restart > counting.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt + DIV_W'(1);
        w_tick_nxt  = w_due;
        w_sq_nxt    = r_sq ^ w_due;

        if (!w_active || w_due) begin
            w_cnt_nxt = '0;
        end

        if ((r_state == ST_SHOT) && w_due) begin
            w_state_nxt = ST_IDLE;
        end

        if (restart && w_active) begin
            w_cnt_nxt = '0;
            w_sq_nxt  = 1'b0;
        end

        if (wr) begin
            w_div_nxt = wr_div;
            w_cnt_nxt = '0;
            w_sq_nxt  = 1'b0;
            if (!wr_en) begin
                w_state_nxt = ST_IDLE;
            end else if (wr_oneshot) begin
                w_state_nxt = ST_SHOT;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    assign tick = r_tick;
    assign sq   = r_sq;
    assign busy = (r_state != ST_IDLE);

endmodule : clkgen_channel
`default_nettype wire

// File: rtl/clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_enable_gen
// Description : Multi-channel programmable clock-enable / square-wave
//               generator. Owns the configuration handshake, channel decode
//               and sync_restart fan-out; counting lives in clkgen_channel.
//   clk_in       in   system clock
//   reset        in   synchronous active-high reset
//   cfg_valid    in   configuration write request
//   cfg_ready    out  block can accept a write (low one cycle after accept)
//   cfg_ch       in   target channel (out-of-range writes are swallowed)
//   cfg_div      in   new divisor (0 behaves as 1)
//   cfg_en       in   1 = start, 0 = stop
//   cfg_oneshot  in   1 = one-shot, 0 = periodic
//   sync_restart in   realign all running channels
//   tick_out     out  per-channel one-cycle enable strobe
//   sq_out       out  per-channel square wave
//   busy         out  per-channel counting flag
// Revision    : 1.0 - initial release
// ============================================================================
module clock_enable_gen
    import clkgen_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                DIV_W       = 16,
    parameter int                DEFAULT_DIV = 50000,
    parameter logic [NUM_CH-1:0] RESET_EN    = NUM_CH'(4'b0001)
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          cfg_en,
    input  logic                          cfg_oneshot,
    input  logic                          sync_restart,
    output logic [NUM_CH-1:0]             tick_out,
    output logic [NUM_CH-1:0]             sq_out,
    output logic [NUM_CH-1:0]             busy
);

    localparam int c_CH_W = ch_width(NUM_CH);

    logic r_ready;
    logic w_accept;

    assign w_accept = cfg_valid && r_ready;

    // One dead cycle after every accepted write, whatever the channel.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_ready <= 1'b1;
        end else begin
            r_ready <= !w_accept;
        end
    end

    assign cfg_ready = r_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_sel;

        assign w_sel = w_accept && (cfg_ch == c_CH_W'(i));

        clkgen_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV),
            .RESET_RUN   (RESET_EN[i])
        ) u_channel (
            .clk_in     (clk_in),
            .reset      (reset),
            .wr         (w_sel),
            .wr_div     (cfg_div),
            .wr_en      (cfg_en),
            .wr_oneshot (cfg_oneshot),
            .restart    (sync_restart),
            .tick       (tick_out[i]),
            .sq         (sq_out[i]),
            .busy       (busy[i])
        );
    end

endmodule : clock_enable_gen
`default_nettype wire
